// File: rtl/seg_scan_decoder.sv
// Scan-bus receiver: rebuilds a 6-digit frame from a multiplexed 7-segment display bus.
// Optional hex letter decode is enabled by defining SEG_DECODE_HEX_EN.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES  = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [5:0]  dig,
  output logic [23:0] digits,
  output logic [5:0]  blank,
  output logic [5:0]  err,
  output logic        frame_done
);

  // state  | meaning
  // WAIT   | bus changing or no single digit selected
  // COUNT  | single digit selected, counting stable samples
  // LOCKED | dwell captured, waiting for the bus to move on
  typedef enum logic [1:0] {WAIT, COUNT, LOCKED} state_t;

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 1);

  state_t        state;
  logic [6:0]    s_seg, p_seg;
  logic [5:0]    s_dig, p_dig;
  logic [CW-1:0] cnt;
  logic [23:0]   sh_val;
  logic [5:0]    sh_blank, sh_err;
  logic [5:0]    mask;

  logic [6:0] lit;
  logic [5:0] sel;
  logic       changed, one_hot, capture;
  logic [5:0] dec;

  // Returns {err, blank, value[3:0]} for a lit pattern {g..a}.
  function automatic logic [5:0] decode(input logic [6:0] p);
    logic [5:0] r;
    r = 6'b10_0000;
    case (p)
      7'b0111111: r = 6'h00;
      7'b0000110: r = 6'h01;
      7'b1011011: r = 6'h02;
      7'b1001111: r = 6'h03;
      7'b1100110: r = 6'h04;
      7'b1101101: r = 6'h05;
      7'b1111101: r = 6'h06;
      7'b0000111: r = 6'h07;
      7'b1111111: r = 6'h08;
      7'b1101111: r = 6'h09;
`ifdef SEG_DECODE_HEX_EN
      7'b1110111: r = 6'h0A;
      7'b1111100: r = 6'h0B;
      7'b0111001: r = 6'h0C;
      7'b1011110: r = 6'h0D;
      7'b1111001: r = 6'h0E;
      7'b1110001: r = 6'h0F;
`else
`endif
      7'b0000000: r = 6'b01_0000;
      default:    r = 6'b10_0000;
    endcase
    return r;
  endfunction

  always_comb begin
    lit     = (SEG_ACTIVE_LOW != 0) ? ~s_seg : s_seg;
    sel     = (DIG_ACTIVE_LOW != 0) ? ~s_dig : s_dig;
    changed = ({s_seg, s_dig} != {p_seg, p_dig});
    one_hot = $onehot(sel);
    capture = (state == COUNT) && !changed && one_hot && (cnt == CNT_CAP);
    dec     = decode(lit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WAIT;
      s_seg      <= '0;
      s_dig      <= '0;
      p_seg      <= '0;
      p_dig      <= '0;
      cnt        <= '0;
      sh_val     <= '0;
      sh_blank   <= '0;
      sh_err     <= '0;
      mask       <= '0;
      digits     <= '0;
      blank      <= 6'h3F;
      err        <= '0;
      frame_done <= 1'b0;
    end else begin
      s_seg <= seg;
      s_dig <= dig;
      p_seg <= s_seg;
      p_dig <= s_dig;

      if (changed)             cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + CW'(1);

      case (state)
        WAIT:    if (one_hot) state <= COUNT;
        COUNT: begin
          if (changed || !one_hot) state <= WAIT;
          else if (capture)        state <= LOCKED;
        end
        LOCKED:  if (changed) state <= WAIT;
        default: state <= WAIT;
      endcase

      if (capture) begin
        for (int i = 0; i < 6; i++) begin
          if (sel[i]) begin
            sh_val[4*i +: 4] <= dec[3:0];
            sh_blank[i]      <= dec[4];
            sh_err[i]        <= dec[5];
          end
        end
      end

      // Commit uses the pre-edge shadow; a same-edge capture lands in the next frame.
      if (mask == 6'h3F) begin
        digits     <= sh_val;
        blank      <= sh_blank;
        err        <= sh_err;
        frame_done <= 1'b1;
        mask       <= capture ? sel : 6'h00;
      end else begin
        frame_done <= 1'b0;
        if (capture) mask <= mask | sel;
      end
    end
  end

endmodule
